pipe_ctrl_regs: RTL and testbench
=================================

Name: pipe_ctrl_regs

Overview:
- Pipeline control-register chain for the 5-stage CPU: carries decoded control bits and destination register from ID through EX, MEM and WB.
- Produces the hazard-side signals the control unit consumes: eRd, eWreg, eReg2reg, eOp, mRd, mWreg.
- Consumes the control unit's STALL and Condep (both active-low) to insert bubbles into EX.
- Keeps saturating stall, flush and retire counters for the debug port.

Parameters:
- CNT_W, 16, width of each event counter.

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Clrn  input  1  synchronous reset, active-low
- Op  input  6  ID-stage opcode
- Rt  input  5  ID-stage rt field
- Rd  input  5  ID-stage rd field
- Regrt  input  1  ID destination select: 1 = Rt, 0 = Rd
- Wreg  input  1  ID register-write enable
- Reg2reg  input  1  ID result select: 0 = memory data (load), 1 = ALU
- Wmem  input  1  ID memory-write enable
- Aluc  input  2  ID ALU function
- Aluqb  input  1  ID ALU B-operand select
- STALL  input  1  active-low: 0 = load-use stall
- Condep  input  1  active-low: 0 = squash ID instruction (taken branch or jump in EX)
- eOp  output  6  EX opcode
- eRd  output  5  EX destination
- eWreg  output  1  EX register-write enable
- eReg2reg  output  1  EX result select
- eWmem  output  1  EX memory write
- eAluc  output  2  EX ALU function
- eAluqb  output  1  EX B-operand select
- mRd  output  5  MEM destination
- mWreg  output  1  MEM register-write enable
- mReg2reg  output  1  MEM result select
- mWmem  output  1  MEM memory write
- wRd  output  5  WB destination
- wWreg  output  1  WB register-write enable
- wReg2reg  output  1  WB result select
- stall_cnt  output  CNT_W  cycles with a stall bubble
- flush_cnt  output  CNT_W  cycles with a squash bubble
- retire_cnt  output  CNT_W  valid instructions leaving WB

Behaviour:
- Reset: when Clrn=0 at a rising Clk edge, all outputs and the internal valid bits (eV, mV, wV) clear to 0. Reset overrides every other input and aborts in-flight instructions.
- Destination: dest = Regrt ? Rt : Rd, forced to 5'b0 when Wreg=0. This prevents spurious forwarding and stalls on non-writing instructions.
- ID->EX (1 cycle): bubble = (STALL==0) | (Condep==0).
  - No bubble: load Op, dest, Wreg, Reg2reg, Wmem, Aluc, Aluqb into the e* registers; eV=1.
  - Bubble: eOp=6'b0, eRd=0, eWreg=0, eWmem=0, eReg2reg=1, eAluc=0, eAluqb=0, eV=0.
  - A bubble eOp of 0 never matches beq (000100), bne (000101) or j (000010), so a bubble cannot re-trigger Condep.
- EX->MEM and MEM->WB: unconditional copy every cycle, with no stall or flush.
  - m* <= e* (Rd, Wreg, Reg2reg, Wmem, valid).
  - w* <= m* (Rd, Wreg, Reg2reg, valid).
  - Stalls only hold IF/ID and PC, which are outside this block.
- Latency: ID inputs appear on e* one cycle later, on m* after two cycles, on w* after three.
- Counters: all saturate at all-ones and never wrap.
  - flush_cnt increments when Condep=0. When Condep=0 and STALL=0 together, only flush_cnt counts.
  - stall_cnt increments when STALL=0 and Condep=1.
  - retire_cnt increments when wV=1.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset: hold Clrn=0 for 2 cycles with random inputs. Required: every output 0, including counters.
2. Straight-line flow: addi Op=001000, Rt=5, Regrt=1, Wreg=1, STALL=1, Condep=1, then 3 idle cycles.
   - Required: eRd=5 at cycle+1, mRd=5/mWreg=1 at +2, wRd=5/wWreg=1 at +3.
   - retire_cnt=1 after cycle +4.
3. Load-use: lw Op=100011, Rt=3, Reg2reg=0, then STALL=0 for one cycle.
   - Required: during the stall cycle eWreg=0, eRd=0 and eOp=0 are written.
   - The lw advances to mRd=3, mReg2reg=0 on schedule.
   - stall_cnt=1.
4. Flush: Condep=0 and STALL=0 in the same cycle. Required: one bubble in EX, flush_cnt=1, stall_cnt unchanged.
5. Non-writer: sw Op=101011, Wreg=0, Rt=7. Required: eRd=0 and eWmem=1.
6. Saturation and mid-run reset: CNT_W=2, hold STALL=0 for 5 cycles.
   - Required: stall_cnt stops at 3.
   - Then Clrn=0 mid-pipeline: required e*, m* and w* all 0 on the next edge.

Source files
------------

// File: rtl/pipe_ctrl_regs.sv
// Control-register chain for the 5-stage CPU: carries decoded control bits and the destination
// register from ID through EX, MEM and WB, inserting EX bubbles on stall/squash.
module pipe_ctrl_regs #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Clrn,
   input  logic [5:0]       Op,
   input  logic [4:0]       Rt,
   input  logic [4:0]       Rd,
   input  logic             Regrt,
   input  logic             Wreg,
   input  logic             Reg2reg,
   input  logic             Wmem,
   input  logic [1:0]       Aluc,
   input  logic             Aluqb,
   input  logic             STALL,
   input  logic             Condep,
   output logic [5:0]       eOp,
   output logic [4:0]       eRd,
   output logic             eWreg,
   output logic             eReg2reg,
   output logic             eWmem,
   output logic [1:0]       eAluc,
   output logic             eAluqb,
   output logic [4:0]       mRd,
   output logic             mWreg,
   output logic             mReg2reg,
   output logic             mWmem,
   output logic [4:0]       wRd,
   output logic             wWreg,
   output logic             wReg2reg,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic       e_v, m_v, w_v;
   logic [4:0] dest;
   logic       bubble;
   logic       stall_ev;
   logic       flush_ev;

   logic [5:0] eop_d;
   logic [4:0] erd_d;
   logic       ewreg_d;
   logic       ereg2reg_d;
   logic       ewmem_d;
   logic [1:0] ealuc_d;
   logic       ealuqb_d;
   logic       ev_d;

   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_d;
   logic [CNT_W-1:0] retire_cnt_d;

   // Non-writers carry dest 0 so the hazard logic never forwards or stalls on them.
   always_comb begin
      dest = Regrt ? Rt : Rd;
      if (!Wreg) begin
         dest = 5'd0;
      end
   end

   // A squash takes priority over a stall when both are asserted.
   always_comb begin
      bubble   = !STALL || !Condep;
      flush_ev = !Condep;
      stall_ev = !STALL && Condep;
   end

   // Bubble opcode 0 matches no branch/jump, so it cannot re-raise Condep.
   always_comb begin
      eop_d      = 6'd0;
      erd_d      = 5'd0;
      ewreg_d    = 1'b0;
      ereg2reg_d = 1'b1;
      ewmem_d    = 1'b0;
      ealuc_d    = 2'd0;
      ealuqb_d   = 1'b0;
      ev_d       = 1'b0;
      if (!bubble) begin
         eop_d      = Op;
         erd_d      = dest;
         ewreg_d    = Wreg;
         ereg2reg_d = Reg2reg;
         ewmem_d    = Wmem;
         ealuc_d    = Aluc;
         ealuqb_d   = Aluqb;
         ev_d       = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d  = stall_cnt;
      flush_cnt_d  = flush_cnt;
      retire_cnt_d = retire_cnt;
      if (stall_ev && (stall_cnt != CntMax)) begin
         stall_cnt_d = stall_cnt + CntOne;
      end
      if (flush_ev && (flush_cnt != CntMax)) begin
         flush_cnt_d = flush_cnt + CntOne;
      end
      if (w_v && (retire_cnt != CntMax)) begin
         retire_cnt_d = retire_cnt + CntOne;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Clrn) begin
         eOp        <= 6'd0;
         eRd        <= 5'd0;
         eWreg      <= 1'b0;
         eReg2reg   <= 1'b0;
         eWmem      <= 1'b0;
         eAluc      <= 2'd0;
         eAluqb     <= 1'b0;
         e_v        <= 1'b0;
         mRd        <= 5'd0;
         mWreg      <= 1'b0;
         mReg2reg   <= 1'b0;
         mWmem      <= 1'b0;
         m_v        <= 1'b0;
         wRd        <= 5'd0;
         wWreg      <= 1'b0;
         wReg2reg   <= 1'b0;
         w_v        <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         eOp        <= eop_d;
         eRd        <= erd_d;
         eWreg      <= ewreg_d;
         eReg2reg   <= ereg2reg_d;
         eWmem      <= ewmem_d;
         eAluc      <= ealuc_d;
         eAluqb     <= ealuqb_d;
         e_v        <= ev_d;
         // EX->MEM->WB never stalls; holding IF/ID and PC is done elsewhere.
         mRd        <= eRd;
         mWreg      <= eWreg;
         mReg2reg   <= eReg2reg;
         mWmem      <= eWmem;
         m_v        <= e_v;
         wRd        <= mRd;
         wWreg      <= mWreg;
         wReg2reg   <= mReg2reg;
         w_v        <= m_v;
         stall_cnt  <= stall_cnt_d;
         flush_cnt  <= flush_cnt_d;
         retire_cnt <= retire_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Self-checking bench for pipe_ctrl_regs: vector table through a latency scoreboard, plus
// reset, counter saturation (CNT_W=2 instance) and mid-pipeline reset sequences.
module tb_pipe_ctrl_regs;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       regrt;
      logic       wreg;
      logic       reg2reg;
      logic       wmem;
      logic [1:0] aluc;
      logic       aluqb;
      logic       stall;
      logic       condep;
   } vin_t;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rd;
      logic       wreg;
      logic       reg2reg;
      logic       wmem;
      logic [1:0] aluc;
      logic       aluqb;
   } eexp_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       wreg;
      logic       reg2reg;
      logic       wmem;
   } mexp_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       wreg;
      logic       reg2reg;
   } wexp_t;

   typedef struct packed {
      vin_t  in;
      eexp_t e;
   } vec_t;

   logic Clk, Clrn;
   logic [5:0] Op;
   logic [4:0] Rt, Rd;
   logic Regrt, Wreg, Reg2reg, Wmem, Aluqb, STALL, Condep;
   logic [1:0] Aluc;

   logic [5:0] eOp;
   logic [4:0] eRd, mRd, wRd;
   logic eWreg, eReg2reg, eWmem, eAluqb, mWreg, mReg2reg, mWmem, wWreg, wReg2reg;
   logic [1:0] eAluc;
   logic [15:0] stall_cnt, flush_cnt, retire_cnt;

   logic [5:0] s_eOp;
   logic [4:0] s_eRd, s_mRd, s_wRd;
   logic s_eWreg, s_eReg2reg, s_eWmem, s_eAluqb, s_mWreg, s_mReg2reg, s_mWmem, s_wWreg, s_wReg2reg;
   logic [1:0] s_eAluc;
   logic [1:0] s_stall_cnt, s_flush_cnt, s_retire_cnt;

   int checks = 0;
   int errors = 0;

   pipe_ctrl_regs #(.CNT_W(16)) dut (
      .Clk(Clk), .Clrn(Clrn), .Op(Op), .Rt(Rt), .Rd(Rd), .Regrt(Regrt), .Wreg(Wreg),
      .Reg2reg(Reg2reg), .Wmem(Wmem), .Aluc(Aluc), .Aluqb(Aluqb), .STALL(STALL),
      .Condep(Condep), .eOp(eOp), .eRd(eRd), .eWreg(eWreg), .eReg2reg(eReg2reg),
      .eWmem(eWmem), .eAluc(eAluc), .eAluqb(eAluqb), .mRd(mRd), .mWreg(mWreg),
      .mReg2reg(mReg2reg), .mWmem(mWmem), .wRd(wRd), .wWreg(wWreg), .wReg2reg(wReg2reg),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
   );

   pipe_ctrl_regs #(.CNT_W(2)) dut_sat (
      .Clk(Clk), .Clrn(Clrn), .Op(Op), .Rt(Rt), .Rd(Rd), .Regrt(Regrt), .Wreg(Wreg),
      .Reg2reg(Reg2reg), .Wmem(Wmem), .Aluc(Aluc), .Aluqb(Aluqb), .STALL(STALL),
      .Condep(Condep), .eOp(s_eOp), .eRd(s_eRd), .eWreg(s_eWreg), .eReg2reg(s_eReg2reg),
      .eWmem(s_eWmem), .eAluc(s_eAluc), .eAluqb(s_eAluqb), .mRd(s_mRd), .mWreg(s_mWreg),
      .mReg2reg(s_mReg2reg), .mWmem(s_mWmem), .wRd(s_wRd), .wWreg(s_wWreg),
      .wReg2reg(s_wReg2reg), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
      .retire_cnt(s_retire_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input vin_t v);
      Op = v.op; Rt = v.rt; Rd = v.rd; Regrt = v.regrt; Wreg = v.wreg;
      Reg2reg = v.reg2reg; Wmem = v.wmem; Aluc = v.aluc; Aluqb = v.aluqb;
      STALL = v.stall; Condep = v.condep;
   endtask

   function automatic vec_t mk(
      input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
      input logic regrt, input logic wreg, input logic r2r, input logic wmem,
      input logic [1:0] aluc, input logic aluqb, input logic stall, input logic condep,
      input logic [5:0] xop, input logic [4:0] xrd, input logic xwreg, input logic xr2r,
      input logic xwmem, input logic [1:0] xaluc, input logic xaluqb);
      vec_t v;
      v.in = '{op: op, rt: rt, rd: rd, regrt: regrt, wreg: wreg, reg2reg: r2r, wmem: wmem,
               aluc: aluc, aluqb: aluqb, stall: stall, condep: condep};
      v.e  = '{op: xop, rd: xrd, wreg: xwreg, reg2reg: xr2r, wmem: xwmem, aluc: xaluc,
               aluqb: xaluqb};
      return v;
   endfunction

   task automatic check_pipe_zero(input string tag);
      check({tag, "_e"}, {15'd0, eOp, eRd, eWreg, eReg2reg, eWmem, eAluc, eAluqb}, 32'd0);
      check({tag, "_m"}, {24'd0, mRd, mWreg, mReg2reg, mWmem}, 32'd0);
      check({tag, "_w"}, {25'd0, wRd, wWreg, wReg2reg}, 32'd0);
      check({tag, "_cnt"}, {stall_cnt, flush_cnt}, 32'd0);
      check({tag, "_ret"}, {16'd0, retire_cnt}, 32'd0);
      check({tag, "_satcnt"}, {26'd0, s_stall_cnt, s_flush_cnt, s_retire_cnt}, 32'd0);
   endtask

   vec_t  vecs[13];
   eexp_t qe[$];
   mexp_t qm[$];
   wexp_t qw[$];
   bit    qv[$];

   initial begin
      int exp_stall, exp_flush, exp_retire;
      vin_t v;
      eexp_t ee;
      mexp_t em;
      wexp_t ew;
      vec_t  cur;

      //             op        rt  rd  rg wr r2 wm al aq st cd | op        rd wr r2 wm al aq
      vecs[0]  = mk(6'b001000, 5,  9,  1, 1, 1, 0, 2, 1, 1, 1, 6'b001000, 5, 1, 1, 0, 2, 1);
      vecs[1]  = mk(6'b000000, 0,  0,  0, 0, 1, 0, 0, 0, 1, 1, 6'b000000, 0, 0, 1, 0, 0, 0);
      vecs[2]  = mk(6'b100011, 3,  0,  1, 1, 0, 0, 0, 1, 1, 1, 6'b100011, 3, 1, 0, 0, 0, 1);
      vecs[3]  = mk(6'b000000, 3,  4,  0, 1, 1, 0, 1, 0, 0, 1, 6'b000000, 0, 0, 1, 0, 0, 0);
      vecs[4]  = mk(6'b000000, 3,  4,  0, 1, 1, 0, 1, 0, 1, 1, 6'b000000, 4, 1, 1, 0, 1, 0);
      vecs[5]  = mk(6'b000100, 2,  6,  0, 0, 1, 0, 3, 0, 0, 0, 6'b000000, 0, 0, 1, 0, 0, 0);
      vecs[6]  = mk(6'b101011, 7,  12, 1, 0, 1, 1, 0, 1, 1, 1, 6'b101011, 0, 0, 1, 1, 0, 1);
      vecs[7]  = mk(6'b000010, 0,  31, 0, 0, 1, 0, 3, 0, 1, 1, 6'b000010, 0, 0, 1, 0, 3, 0);
      vecs[8]  = mk(6'b001000, 8,  8,  1, 1, 1, 0, 2, 1, 1, 0, 6'b000000, 0, 0, 1, 0, 0, 0);
      vecs[9]  = mk(6'b001101, 10, 20, 1, 1, 1, 0, 1, 1, 1, 1, 6'b001101, 10, 1, 1, 0, 1, 1);
      vecs[10] = mk(6'b000000, 0,  0,  0, 0, 1, 0, 0, 0, 1, 1, 6'b000000, 0, 0, 1, 0, 0, 0);
      vecs[11] = vecs[10];
      vecs[12] = vecs[10];

      // Reset with random inputs.
      Clrn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         v = vin_t'($urandom);
         v.op = 6'($urandom);
         drive(v);
         tick();
      end
      check_pipe_zero("reset");

      // Table run: reset contents are the in-flight m/w/retire state for the first cycles.
      Clrn = 1'b1;
      qm.push_back('0);
      qw.push_back('0);
      qw.push_back('0);
      repeat (3) qv.push_back(1'b0);
      exp_stall = 0; exp_flush = 0; exp_retire = 0;
      for (int i = 0; i < 13; i++) begin
         cur = vecs[i];
         drive(cur.in);
         qe.push_back(cur.e);
         qm.push_back('{rd: cur.e.rd, wreg: cur.e.wreg, reg2reg: cur.e.reg2reg,
                        wmem: cur.e.wmem});
         qw.push_back('{rd: cur.e.rd, wreg: cur.e.wreg, reg2reg: cur.e.reg2reg});
         qv.push_back(cur.in.stall && cur.in.condep);
         if (!cur.in.condep) exp_flush++;
         else if (!cur.in.stall) exp_stall++;
         if (qv.pop_front()) exp_retire++;
         tick();
         ee = qe.pop_front();
         em = qm.pop_front();
         ew = qw.pop_front();
         check($sformatf("e[%0d]", i), {15'd0, eOp, eRd, eWreg, eReg2reg, eWmem, eAluc, eAluqb},
               {15'd0, ee});
         check($sformatf("m[%0d]", i), {24'd0, mRd, mWreg, mReg2reg, mWmem}, {24'd0, em});
         check($sformatf("w[%0d]", i), {25'd0, wRd, wWreg, wReg2reg}, {25'd0, ew});
         check($sformatf("stall_cnt[%0d]", i), {16'd0, stall_cnt}, exp_stall);
         check($sformatf("flush_cnt[%0d]", i), {16'd0, flush_cnt}, exp_flush);
         check($sformatf("retire_cnt[%0d]", i), {16'd0, retire_cnt}, exp_retire);
      end

      // Saturation on the CNT_W=2 instance, then a mid-pipeline reset.
      Clrn = 1'b0;
      drive(vecs[10].in);
      tick();
      Clrn = 1'b1;
      v = vecs[3].in;
      for (int i = 0; i < 5; i++) begin
         drive(v);
         tick();
      end
      check("sat_stall", {30'd0, s_stall_cnt}, 32'd3);
      check("wide_stall", {16'd0, stall_cnt}, 32'd5);
      v.stall = 1'b1;
      v.condep = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(v);
         tick();
      end
      check("sat_flush", {30'd0, s_flush_cnt}, 32'd3);
      check("sat_stall_hold", {30'd0, s_stall_cnt}, 32'd3);
      drive(vecs[0].in);
      for (int i = 0; i < 7; i++) tick();
      check("mid_w", {25'd0, wRd, wWreg, wReg2reg}, {25'd0, 5'd5, 1'b1, 1'b1});
      check("mid_m", {24'd0, mRd, mWreg, mReg2reg, mWmem}, {24'd0, 5'd5, 1'b1, 1'b1, 1'b0});
      check("sat_retire", {30'd0, s_retire_cnt}, 32'd3);
      check("wide_retire", {16'd0, retire_cnt}, 32'd4);
      Clrn = 1'b0;
      tick();
      check_pipe_zero("midreset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
